// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default sizes and address helper for regfile_sb
// Contents: rf_state_t (INIT/RUN), RF_N / RF_DEPTH defaults, rf_legal() address check.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  localparam int RF_N     = 64;
  localparam int RF_DEPTH = 32;

  // A register address is usable when it exists and is not the hardwired zero register.
  function automatic logic rf_legal(input int a, input int depth, input int zr);
    return (a < depth) && (a != zr);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - register file access bus: write port, two read ports, reserve port
// Signals: we3/wa3/wd3 write, ra1/ra2 -> rd1/rd2 read, rsv_en/rsv_a reserve,
//          busy1/busy2 pending-write flags, ready init done.
// Modports: master drives requests, slave (regfile_sb) drives read data and status.
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int N  = RF_N,
  parameter int AW = $clog2(RF_DEPTH)
) ();

  logic          we3;
  logic [AW-1:0] wa3;
  logic [N-1:0]  wd3;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [N-1:0]  rd1;
  logic [N-1:0]  rd2;
  logic          rsv_en;
  logic [AW-1:0] rsv_a;
  logic          busy1;
  logic          busy2;
  logic          ready;

  modport master (
    output we3, wa3, wd3, ra1, ra2, rsv_en, rsv_a,
    input  rd1, rd2, busy1, busy2, ready
  );

  modport slave (
    input  we3, wa3, wd3, ra1, ra2, rsv_en, rsv_a,
    output rd1, rd2, busy1, busy2, ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - one busy bit per register with set/clear and set-wins priority
// Ports: clk, reset (async active-low), set_en/set_a reserve, clr_en/clr_a committed write,
//        ra1/ra2 lookup addresses, busy1/busy2 stored busy state (0 for out-of-range).
// Callers qualify set_en/clr_en; this block trusts them to be legal addresses.
module regfile_scoreboard #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_a,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_a,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2
);

  logic [DEPTH-1:0] busy;

  // The set is applied after the clear so a same-address reserve overrides the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_a] <= 1'b0;
      if (set_en) busy[set_a] <= 1'b1;
    end
  end

  assign busy1 = (int'(ra1) < DEPTH) ? busy[ra1] : 1'b0;
  assign busy2 = (int'(ra2) < DEPTH) ? busy[ra2] : 1'b0;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2-read/1-write register file with zero register, self-init and scoreboard
// Ports: clk, reset (async active-low), bus (regfile_sb_if.slave).
// After reset the INIT state writes reg[i]=i (reg[ZR]=0) one per cycle, then RUN.
// Macro REGFILE_FWD_EN: when defined, a same-cycle RUN write bypasses to the read
// ports and masks the busy flag of the matching port.
module regfile_sb import regfile_pkg::*; #(
  parameter int N     = RF_N,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int ZR    = DEPTH - 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          init_we;
  logic [N-1:0]  init_val;
  logic [N-1:0]  mem [DEPTH];
  logic          run, wr_ok, rsv_ok;
  logic [N-1:0]  st1, st2;
  logic          sb_busy1, sb_busy2;
  logic          fwd1, fwd2;

  assign run    = (state == RUN);
  assign wr_ok  = run && bus.we3    && rf_legal(int'(bus.wa3),   DEPTH, ZR);
  assign rsv_ok = run && bus.rsv_en && rf_legal(int'(bus.rsv_a), DEPTH, ZR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        if (int'(cnt) == DEPTH - 1) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign init_val = (int'(cnt) == ZR) ? '0 : N'(cnt);

  // No reset on the array: the INIT sweep is what gives it defined contents.
  // While reset is held the sweep sits at index 0 and rewrites reg[0]=0, which is harmless.
  always_ff @(posedge clk) begin
    if (init_we)    mem[cnt]     <= init_val;
    else if (wr_ok) mem[bus.wa3] <= bus.wd3;
  end

  always_comb begin
    st1 = rf_legal(int'(bus.ra1), DEPTH, ZR) ? mem[bus.ra1] : '0;
    st2 = rf_legal(int'(bus.ra2), DEPTH, ZR) ? mem[bus.ra2] : '0;
  end

  regfile_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_en (rsv_ok),
    .set_a  (bus.rsv_a),
    .clr_en (wr_ok),
    .clr_a  (bus.wa3),
    .ra1    (bus.ra1),
    .ra2    (bus.ra2),
    .busy1  (sb_busy1),
    .busy2  (sb_busy2)
  );

`ifdef REGFILE_FWD_EN
  assign fwd1 = wr_ok && (bus.wa3 == bus.ra1);
  assign fwd2 = wr_ok && (bus.wa3 == bus.ra2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign bus.rd1   = fwd1 ? bus.wd3 : st1;
  assign bus.rd2   = fwd2 ? bus.wd3 : st2;
  assign bus.busy1 = sb_busy1 && !fwd1;
  assign bus.busy2 = sb_busy2 && !fwd2;
  assign bus.ready = run;

endmodule
